// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: register map, handshake states and byte-merge helper for the bus timer.
package bus_timer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_RELEASE} bus_state_t;

    localparam int REG_MTIME_LO = 0;
    localparam int REG_MTIME_HI = 1;
    localparam int REG_CMP_LO   = 2;
    localparam int REG_CMP_HI   = 3;
    localparam int REG_CTRL     = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_DIV_LSB = 8;

    localparam logic [63:0] MTIMECMP_RST = '1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wd,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : cur[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/bus_slave_fsm.sv
// bus_slave_fsm: IDLE/ACK/RELEASE responder handshake with request latch.
module bus_slave_fsm
    import bus_timer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int OFFS_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_en,
    input  logic              wr_en,
    input  logic [OFFS_W-3:0] offs,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [3:0]        byte_en,
    output logic              take,
    output logic              ack,
    output logic              req_wr,
    output logic [OFFS_W-3:0] req_offs,
    output logic [XLEN-1:0]   req_wdata,
    output logic [3:0]        req_be
);

    bus_state_t state;

    assign take = state == ST_IDLE && bus_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ack       <= 1'b0;
            req_wr    <= 1'b0;
            req_offs  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else begin
            ack <= take;
            if (take) begin
                req_wr    <= wr_en;
                req_offs  <= offs;
                req_wdata <= wr_data;
                req_be    <= byte_en;
            end
            // ACK always moves on, so a dropped request still completes its single ack
            state <= take ? ST_ACK :
                     state == ST_ACK ? ST_RELEASE :
                     (state == ST_RELEASE && !bus_en) ? ST_IDLE : state;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 64-bit mtime/mtimecmp machine timer with prescaler.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PRESC_W = 8,
    parameter int OFFS_W  = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_bus_en,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [3:0]      i_byte_en,
    output logic            o_ack,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_tip
);

    localparam int OW = OFFS_W - 2;
    localparam logic [XLEN-1:0] CTRL_MASK =
        (XLEN'({PRESC_W{1'b1}}) << CTRL_DIV_LSB) | XLEN'(1 << CTRL_EN);

    logic [63:0]        mtime, mtimecmp;
    logic [XLEN-1:0]    ctrl, rd_word, req_wdata;
    logic [PRESC_W-1:0] presc_cnt, div;
    logic [OW-1:0]      offs, req_offs;
    logic [3:0]         req_be;
    logic               take, req_wr, commit, en, tick;
    logic               wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;
    logic               addr_unused;

    assign offs        = i_addr[OFFS_W-1:2];
    assign addr_unused = ^{i_addr[XLEN-1:OFFS_W], i_addr[1:0]};

    bus_slave_fsm #(.XLEN(XLEN), .OFFS_W(OFFS_W)) u_fsm (
        .clk      (i_clk),
        .rst      (i_rst),
        .bus_en   (i_bus_en),
        .wr_en    (i_wr_en),
        .offs     (offs),
        .wr_data  (i_wr_data),
        .byte_en  (i_byte_en),
        .take     (take),
        .ack      (o_ack),
        .req_wr   (req_wr),
        .req_offs (req_offs),
        .req_wdata(req_wdata),
        .req_be   (req_be)
    );

    assign commit  = o_ack && req_wr;
    assign wr_mlo  = commit && req_offs == OW'(REG_MTIME_LO);
    assign wr_mhi  = commit && req_offs == OW'(REG_MTIME_HI);
    assign wr_clo  = commit && req_offs == OW'(REG_CMP_LO);
    assign wr_chi  = commit && req_offs == OW'(REG_CMP_HI);
    assign wr_ctrl = commit && req_offs == OW'(REG_CTRL);

    assign en   = ctrl[CTRL_EN];
    assign div  = ctrl[CTRL_DIV_LSB +: PRESC_W];
    assign tick = en && presc_cnt == div;

    always_comb begin
        rd_word = offs == OW'(REG_MTIME_LO) ? mtime[31:0] :
                  offs == OW'(REG_MTIME_HI) ? mtime[63:32] :
                  offs == OW'(REG_CMP_LO)   ? mtimecmp[31:0] :
                  offs == OW'(REG_CMP_HI)   ? mtimecmp[63:32] :
                  offs == OW'(REG_CTRL)     ? ctrl : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtime     <= '0;
            mtimecmp  <= MTIMECMP_RST;
            ctrl      <= '0;
            presc_cnt <= '0;
            o_tip     <= 1'b0;
            o_rd_data <= '0;
        end else begin
            o_tip <= mtime >= mtimecmp;
            if (take) o_rd_data <= i_wr_en ? '0 : rd_word;
            if (wr_ctrl) presc_cnt <= '0;
            else if (en) presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            // a software write to either half suppresses that cycle's tick entirely
            if (wr_mlo) mtime[31:0] <= merge_bytes(mtime[31:0], req_wdata, req_be);
            else if (wr_mhi) mtime[63:32] <= merge_bytes(mtime[63:32], req_wdata, req_be);
            else if (tick) mtime <= mtime + 64'd1;
            if (wr_clo) mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], req_wdata, req_be);
            if (wr_chi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], req_wdata, req_be);
            if (wr_ctrl) ctrl <= merge_bytes(ctrl, req_wdata, req_be) & CTRL_MASK;
        end
    end

endmodule
